// File: rtl/subtractor_serial32.sv
// subtractor_serial32: multi-cycle ripple-borrow subtractor, CHUNK bits per cycle, LSB chunk first
module subtractor_serial32 #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic             r_borrow;
   logic             r_a_msb;
   logic             r_b_msb;
   logic [CW-1:0]    r_cnt;
   logic [CHUNK:0]   w_sub;
   logic [WIDTH-1:0] w_acc;
   logic             w_last;
   // operands shift right each cycle, so the active chunk is always the low CHUNK bits
   assign w_sub  = {1'b0, r_a[CHUNK-1:0]} - {1'b0, r_b[CHUNK-1:0]} - {{CHUNK{1'b0}}, r_borrow};
   // new chunk enters at the top of the accumulator; after N steps chunk 0 sits at the bottom
   assign w_acc  = WIDTH'({w_sub[CHUNK-1:0], r_acc} >> CHUNK);
   assign w_last = r_cnt == CW'(N - 1);
   assign busy   = r_state == S_RUN;
   assign done   = r_state == S_DONE;
   // control FSM and datapath; diff/bout/ovf change only on the final RUN edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_borrow <= 1'b0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_cnt    <= '0;
         diff     <= '0;
         bout     <= 1'b0;
         ovf      <= 1'b0;
      end else if (r_state == S_RUN) begin
         r_a      <= r_a >> CHUNK;
         r_b      <= r_b >> CHUNK;
         r_acc    <= w_acc;
         r_borrow <= w_sub[CHUNK];
         r_cnt    <= r_cnt + CW'(1);
         if (w_last) begin
            r_state <= S_DONE;
            diff    <= w_acc;
            bout    <= w_sub[CHUNK];
            ovf     <= (r_a_msb != r_b_msb) && (w_sub[CHUNK-1] != r_a_msb);
         end
      end else if (start) begin
         r_state  <= S_RUN;
         r_a      <= op1;
         r_b      <= op2;
         r_acc    <= '0;
         r_borrow <= bin;
         r_a_msb  <= op1[WIDTH-1];
         r_b_msb  <= op2[WIDTH-1];
         r_cnt    <= '0;
      end else begin
         r_state <= S_IDLE;
      end
   end
endmodule
